// File: rtl/snitch_dmem_responder.sv
// snitch_dmem_responder: flop-based scratch memory serving loads, strobed
// stores and AMOs from one initiator, answered in order via a response FIFO.
module snitch_dmem_responder #(
    parameter int unsigned NumWords    = 1024,
    parameter int unsigned RespDepth   = 2,
    parameter int unsigned MetaIdWidth = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [31:0]            data_qaddr_i,
    input  logic [MetaIdWidth-1:0] data_qid_i,
    input  logic [3:0]             data_qamo_i,
    input  logic                   data_qwrite_i,
    input  logic [31:0]            data_qdata_i,
    input  logic [3:0]             data_qstrb_i,
    input  logic                   data_qvalid_i,
    output logic                   data_qready_o,
    output logic [31:0]            data_pdata_o,
    output logic [MetaIdWidth-1:0] data_pid_o,
    output logic                   data_pwrite_o,
    output logic                   data_perror_o,
    output logic                   data_pvalid_o,
    input  logic                   data_pready_i
);

    localparam int unsigned AddrBits = $clog2(NumWords);
    localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int unsigned CntW = $clog2(RespDepth + 1);
    localparam logic [32:0] ByteLimit = 33'(NumWords) * 33'd4;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StAmoWr = 1'b1;

    typedef struct packed {
        logic [31:0]            data;
        logic [MetaIdWidth-1:0] id;
        logic                   write;
        logic                   error;
    } resp_t;

    logic [31:0]            mem_q [NumWords];
    resp_t                  fifo_q [RespDepth];

    logic [0:0]             state_q, state_d;
    logic [3:0]             amo_op_q, amo_op_d;
    logic [AddrBits-1:0]    amo_idx_q, amo_idx_d;
    logic [31:0]            amo_old_q, amo_old_d;
    logic [31:0]            amo_arg_q, amo_arg_d;
    logic [MetaIdWidth-1:0] amo_id_q, amo_id_d;
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        cnt_q, cnt_d;

    logic [AddrBits-1:0]    req_idx;
    logic                   req_err;
    logic                   req_hs;
    logic                   push;
    logic                   pop;
    resp_t                  push_data;
    resp_t                  head;
    logic                   mem_we;
    logic [3:0]             mem_be;
    logic [AddrBits-1:0]    mem_idx;
    logic [31:0]            mem_wdata;
    logic [31:0]            amo_new;

    assign req_idx = data_qaddr_i[2 +: AddrBits];
    assign req_err = ({1'b0, data_qaddr_i} >= ByteLimit)
                   | (data_qaddr_i[1:0] != 2'b00)
                   | (data_qamo_i > 4'd9);

    assign data_qready_o = (state_q == StIdle) && (cnt_q < CntW'(RespDepth));
    assign req_hs = data_qvalid_i && data_qready_o;

    always_comb begin
        amo_new = amo_arg_q;
        unique case (amo_op_q)
            4'd2: amo_new = amo_old_q + amo_arg_q;
            4'd3: amo_new = amo_old_q & amo_arg_q;
            4'd4: amo_new = amo_old_q | amo_arg_q;
            4'd5: amo_new = amo_old_q ^ amo_arg_q;
            4'd6: amo_new = ($signed(amo_old_q) > $signed(amo_arg_q)) ? amo_old_q : amo_arg_q;
            4'd7: amo_new = (amo_old_q > amo_arg_q) ? amo_old_q : amo_arg_q;
            4'd8: amo_new = ($signed(amo_old_q) < $signed(amo_arg_q)) ? amo_old_q : amo_arg_q;
            4'd9: amo_new = (amo_old_q < amo_arg_q) ? amo_old_q : amo_arg_q;
            default: amo_new = amo_arg_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        amo_op_d  = amo_op_q;
        amo_idx_d = amo_idx_q;
        amo_old_d = amo_old_q;
        amo_arg_d = amo_arg_q;
        amo_id_d  = amo_id_q;
        push      = 1'b0;
        push_data = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_idx   = req_idx;
        mem_wdata = data_qdata_i;
        unique case (state_q)
            StIdle: begin
                if (req_hs) begin
                    push_data.id = data_qid_i;
                    if (req_err) begin
                        push            = 1'b1;
                        push_data.write = data_qwrite_i;
                        push_data.error = 1'b1;
                    end else if (data_qamo_i != 4'd0) begin
                        // old value captured now; write-back happens next cycle
                        state_d   = StAmoWr;
                        amo_op_d  = data_qamo_i;
                        amo_idx_d = req_idx;
                        amo_old_d = mem_q[req_idx];
                        amo_arg_d = data_qdata_i;
                        amo_id_d  = data_qid_i;
                    end else if (data_qwrite_i) begin
                        push            = 1'b1;
                        push_data.write = 1'b1;
                        mem_we          = 1'b1;
                        mem_be          = data_qstrb_i;
                    end else begin
                        push           = 1'b1;
                        push_data.data = mem_q[req_idx];
                    end
                end
            end
            StAmoWr: begin
                push           = 1'b1;
                push_data.data = amo_old_q;
                push_data.id   = amo_id_q;
                mem_we         = 1'b1;
                mem_be         = 4'hF;
                mem_idx        = amo_idx_q;
                mem_wdata      = amo_new;
                state_d        = StIdle;
            end
        endcase
    end

    assign pop = (cnt_q != '0) && data_pready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(RespDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(RespDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    assign head          = fifo_q[rd_ptr_q];
    assign data_pvalid_o = (cnt_q != '0);
    assign data_pdata_o  = data_pvalid_o ? head.data : '0;
    assign data_pid_o    = data_pvalid_o ? head.id : '0;
    assign data_pwrite_o = data_pvalid_o & head.write;
    assign data_perror_o = data_pvalid_o & head.error;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            amo_op_q  <= '0;
            amo_idx_q <= '0;
            amo_old_q <= '0;
            amo_arg_q <= '0;
            amo_id_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            amo_op_q  <= amo_op_d;
            amo_idx_q <= amo_idx_d;
            amo_old_q <= amo_old_d;
            amo_arg_q <= amo_arg_d;
            amo_id_q  <= amo_id_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RespDepth; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumWords; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_snitch_dmem_responder.sv
// tb_snitch_dmem_responder: directed and random requests checked against a
// word-array memory model and an in-order queue of expected responses.
module tb_snitch_dmem_responder;

    localparam int NW = 1024;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] data_qaddr_i = '0;
    logic [2:0]  data_qid_i = '0;
    logic [3:0]  data_qamo_i = '0;
    logic        data_qwrite_i = 1'b0;
    logic [31:0] data_qdata_i = '0;
    logic [3:0]  data_qstrb_i = '0;
    logic        data_qvalid_i = 1'b0;
    logic        data_qready_o;
    logic [31:0] data_pdata_o;
    logic [2:0]  data_pid_o;
    logic        data_pwrite_o;
    logic        data_perror_o;
    logic        data_pvalid_o;
    logic        data_pready_i = 1'b1;

    snitch_dmem_responder #(
        .NumWords(NW), .RespDepth(2), .MetaIdWidth(3)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .data_qaddr_i(data_qaddr_i), .data_qid_i(data_qid_i),
        .data_qamo_i(data_qamo_i), .data_qwrite_i(data_qwrite_i),
        .data_qdata_i(data_qdata_i), .data_qstrb_i(data_qstrb_i),
        .data_qvalid_i(data_qvalid_i), .data_qready_o(data_qready_o),
        .data_pdata_o(data_pdata_o), .data_pid_o(data_pid_o),
        .data_pwrite_o(data_pwrite_o), .data_perror_o(data_perror_o),
        .data_pvalid_o(data_pvalid_o), .data_pready_i(data_pready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  id;
        logic        w;
        logic        e;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_en = 1'b0;
    logic [31:0] mem_m [NW];
    exp_t        exp_q [$];
    int          id_log [$];
    logic [31:0] last_pdata;
    logic [2:0]  last_pid;
    logic        last_pwrite;
    logic        last_perror;
    bit          rand_done;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_accept();
        exp_t        e;
        logic [31:0] old;
        logic [31:0] nw;
        logic [31:0] opnd;
        int          idx;
        bit          err;
        err = (data_qaddr_i >= 32'(NW * 4)) || (data_qaddr_i % 4 != 0)
            || (data_qamo_i > 4'd9);
        idx = int'(data_qaddr_i / 4);
        e.id = data_qid_i;
        e.d = '0;
        e.w = 1'b0;
        e.e = 1'b0;
        if (err) begin
            e.e = 1'b1;
            e.w = data_qwrite_i;
        end else if (data_qamo_i == 0 && data_qwrite_i) begin
            e.w = 1'b1;
            for (int b = 0; b < 4; b++)
                if (data_qstrb_i[b]) mem_m[idx][8*b +: 8] = data_qdata_i[8*b +: 8];
        end else if (data_qamo_i == 0) begin
            e.d = mem_m[idx];
        end else begin
            old = mem_m[idx];
            opnd = data_qdata_i;
            case (data_qamo_i)
                4'd1: nw = opnd;
                4'd2: nw = old + opnd;
                4'd3: nw = old & opnd;
                4'd4: nw = old | opnd;
                4'd5: nw = old ^ opnd;
                4'd6: nw = ($signed(old) > $signed(opnd)) ? old : opnd;
                4'd7: nw = (old > opnd) ? old : opnd;
                4'd8: nw = ($signed(old) < $signed(opnd)) ? old : opnd;
                4'd9: nw = (old < opnd) ? old : opnd;
                default: nw = old;
            endcase
            mem_m[idx] = nw;
            e.d = old;
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clk_i) begin
        if (mon_en) begin
            if (data_pvalid_o && data_pready_i) begin
                check_eq("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("rsp_data", data_pdata_o, e.d);
                    check_eq("rsp_id", 32'(data_pid_o), 32'(e.id));
                    check_eq("rsp_write", 32'(data_pwrite_o), 32'(e.w));
                    check_eq("rsp_error", 32'(data_perror_o), 32'(e.e));
                end
                last_pdata  = data_pdata_o;
                last_pid    = data_pid_o;
                last_pwrite = data_pwrite_o;
                last_perror = data_perror_o;
                id_log.push_back(int'(data_pid_o));
            end
            if (data_qvalid_i && data_qready_o) model_accept();
        end
    end

    // call at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic issue(input logic [31:0] addr, input logic [2:0] id,
                         input logic [3:0] amo, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        int n = 0;
        data_qaddr_i  = addr;
        data_qid_i    = id;
        data_qamo_i   = amo;
        data_qwrite_i = wr;
        data_qdata_i  = wdata;
        data_qstrb_i  = strb;
        data_qvalid_i = 1'b1;
        forever begin
            @(negedge clk_i);
            if (data_qready_o) break;
            n++;
            if (n > 200) begin
                check_eq("req_timeout", 32'(data_qready_o), 32'd1);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        data_qvalid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        data_pready_i = 1'b1;
        while ((exp_q.size() != 0 || data_pvalid_o) && n < 100) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic load_expect(input string tag, input logic [31:0] addr,
                               input logic [31:0] exp);
        issue(addr, 3'd7, 4'd0, 1'b0, '0, '0);
        drain();
        check_eq(tag, last_pdata, exp);
    endtask

    initial begin
        int nxt;
        foreach (mem_m[i]) mem_m[i] = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        mon_en = 1'b1;
        @(negedge clk_i);
        check_eq("rst_qready", 32'(data_qready_o), 32'd1);
        check_eq("rst_pvalid", 32'(data_pvalid_o), 32'd0);
        check_eq("rst_pdata", data_pdata_o, 32'd0);
        check_eq("rst_pid", 32'(data_pid_o), 32'd0);
        check_eq("rst_pwrite", 32'(data_pwrite_o), 32'd0);
        check_eq("rst_perror", 32'(data_perror_o), 32'd0);
        @(posedge clk_i);
        #1;

        issue(32'h10, 3'd1, 4'd0, 1'b0, '0, '0);
        check_eq("load_latency", 32'(data_pvalid_o), 32'd1);
        drain();
        check_eq("load_zero", last_pdata, 32'd0);
        check_eq("load_noerr", 32'(last_perror), 32'd0);

        issue(32'h40, 3'd5, 4'd0, 1'b1, 32'hAABBCCDD, 4'b0101);
        drain();
        check_eq("st_pwrite", 32'(last_pwrite), 32'd1);
        check_eq("st_pid", 32'(last_pid), 32'd5);
        check_eq("st_pdata", last_pdata, 32'd0);
        load_expect("st_reload", 32'h40, 32'h00BB00DD);

        issue(32'h0, 3'd2, 4'd0, 1'b1, 32'hFFFFFFFF, 4'hF);
        drain();
        issue(32'h0, 3'd3, 4'd2, 1'b0, 32'd2, 4'h0);
        check_eq("amo_qready_low", 32'(data_qready_o), 32'd0);
        check_eq("amo_no_early", 32'(data_pvalid_o), 32'd0);
        @(posedge clk_i);
        #1;
        check_eq("amo_qready_back", 32'(data_qready_o), 32'd1);
        check_eq("amo_pvalid", 32'(data_pvalid_o), 32'd1);
        drain();
        check_eq("amo_add_old", last_pdata, 32'hFFFFFFFF);
        check_eq("amo_add_pid", 32'(last_pid), 32'd3);
        check_eq("amo_add_pwrite", 32'(last_pwrite), 32'd0);
        load_expect("amo_add_new", 32'h0, 32'h1);

        issue(32'h20, 3'd0, 4'd0, 1'b1, 32'h80000000, 4'hF);
        issue(32'h20, 3'd1, 4'd8, 1'b0, 32'd1, 4'h0);
        drain();
        load_expect("amo_min", 32'h20, 32'h80000000);
        issue(32'h24, 3'd0, 4'd0, 1'b1, 32'h80000000, 4'hF);
        issue(32'h24, 3'd1, 4'd9, 1'b0, 32'd1, 4'h0);
        drain();
        load_expect("amo_minu", 32'h24, 32'h1);

        issue(32'(NW * 4), 3'd4, 4'd0, 1'b0, '0, '0);
        drain();
        check_eq("err_oob", 32'(last_perror), 32'd1);
        check_eq("err_oob_data", last_pdata, 32'd0);
        issue(32'h2, 3'd4, 4'd0, 1'b1, 32'h12345678, 4'hF);
        drain();
        check_eq("err_mis", 32'(last_perror), 32'd1);
        check_eq("err_mis_pwrite", 32'(last_pwrite), 32'd1);
        issue(32'h40, 3'd4, 4'hA, 1'b0, 32'hFFFFFFFF, 4'hF);
        drain();
        check_eq("err_amo", 32'(last_perror), 32'd1);
        check_eq("err_amo_data", last_pdata, 32'd0);
        load_expect("err_keep0", 32'h0, 32'h1);
        load_expect("err_keep40", 32'h40, 32'h00BB00DD);

        id_log.delete();
        data_pready_i = 1'b0;
        nxt = 0;
        for (int c = 0; c < 12; c++) begin
            if (nxt < 4) begin
                data_qvalid_i = 1'b1;
                data_qid_i    = 3'(nxt);
                data_qaddr_i  = 32'h100 + 32'(4 * nxt);
                data_qamo_i   = 4'd0;
                data_qwrite_i = 1'b0;
            end else begin
                data_qvalid_i = 1'b0;
            end
            if (c == 8) data_pready_i = 1'b1;
            @(negedge clk_i);
            if (c >= 2 && c < 8) begin
                check_eq("bp_qready", 32'(data_qready_o), 32'd0);
                check_eq("bp_head_id", 32'(data_pid_o), 32'd0);
            end
            if (c == 7) check_eq("bp_accepted", 32'(nxt), 32'd2);
            if (data_qvalid_i && data_qready_o) nxt++;
            @(posedge clk_i);
            #1;
        end
        data_qvalid_i = 1'b0;
        drain();
        check_eq("bp_count", 32'(id_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < id_log.size()) check_eq("bp_order", 32'(id_log[i]), 32'(i));
        end

        issue(32'h200, 3'd6, 4'd0, 1'b1, 32'h5A5A5A5A, 4'hF);
        drain();
        issue(32'h200, 3'd6, 4'd1, 1'b0, 32'h1234, 4'h0);
        mon_en = 1'b0;
        rst_ni = 1'b0;
        exp_q.delete();
        foreach (mem_m[i]) mem_m[i] = '0;
        #1;
        check_eq("rst_amo_pvalid", 32'(data_pvalid_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        mon_en = 1'b1;
        check_eq("rst_amo_qready", 32'(data_qready_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_eq("rst_amo_norsp", 32'(data_pvalid_o), 32'd0);
        end
        @(posedge clk_i);
        #1;
        load_expect("rst_amo_mem", 32'h200, 32'h0);

        rand_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    logic [31:0] a;
                    logic [3:0]  amo;
                    int          sel;
                    sel = int'($urandom_range(0, 15));
                    if (sel == 0) a = $urandom;
                    else if (sel == 1)
                        a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
                    else a = 32'($urandom_range(0, 31)) << 2;
                    amo = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 10)) : 4'd0;
                    issue(a, 3'($urandom), amo, 1'($urandom), $urandom, 4'($urandom));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk_i);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    data_pready_i = ($urandom_range(0, 3) != 0);
                    @(posedge clk_i);
                    #1;
                end
                data_pready_i = 1'b1;
            end
        join
        drain();
        for (int w = 0; w < 32; w++) load_expect("rand_final", 32'(4 * w), mem_m[w]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
